mem_req_ctrl: RTL

- Processor-side memory-stage controller that sits directly upstream of mem_system.
- Accepts one load/store request at a time from the pipeline and drives mem_system's Rd/Wr/Addr/DataIn, holding them stable until Done.
- Returns load data, stalls the pipeline while a request is outstanding, flags misaligned, timed-out or memory-error accesses, and keeps access/hit statistics.

---
 rtl/mem_req_ctrl_pkg.sv | 17 +
 rtl/mem_req_ctrl_if.sv | 44 ++++
 rtl/mem_req_ctrl_sat_counter.sv | 38 +++
 rtl/mem_req_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the memory-stage request controller.
//   state_e : controller FSM states
//   WORD_W  : data word width
//   ADDR_W  : byte address width
package mem_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Bus bundle between the pipeline, the request controller and mem_system.
// Pipeline side : req_valid/req_wr/req_addr/req_wdata in, req_ready/stall/
//                 resp_valid/resp_rdata out.
// Memory side   : mem_Rd/mem_Wr/mem_Addr/mem_DataIn/mem_createdump out,
//                 mem_DataOut/mem_Done/mem_Stall/mem_CacheHit/mem_err in.
// master = the controller, slave = its environment (pipeline + mem_system).
interface mem_req_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;

  logic              mem_Rd;
  logic              mem_Wr;
  logic [ADDR_W-1:0] mem_Addr;
  logic [WORD_W-1:0] mem_DataIn;
  logic              mem_createdump;
  logic [WORD_W-1:0] mem_DataOut;
  logic              mem_Done;
  logic              mem_Stall;
  logic              mem_CacheHit;
  logic              mem_err;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_rdata,
    output mem_Rd, mem_Wr, mem_Addr, mem_DataIn, mem_createdump,
    input  mem_DataOut, mem_Done, mem_Stall, mem_CacheHit, mem_err
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_rdata,
    input  mem_Rd, mem_Wr, mem_Addr, mem_DataIn, mem_createdump,
    output mem_DataOut, mem_Done, mem_Stall, mem_CacheHit, mem_err
  );

endinterface

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count up by one (holds at all-ones)
//   clear    : return to zero (wins over inc)
//   cnt      : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller placed directly upstream of mem_system.
// Takes one load/store at a time, drives and holds the mem_system request
// until Done, returns load data, stalls the pipeline while busy, and traps
// misaligned, timed-out or failed accesses in a sticky error state.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : pipeline + mem_system signals (mem_req_ctrl_if.master)
//   err        : sticky error flag
//   access_cnt : completed accesses (saturating)
//   hit_cnt    : completed accesses that hit in the cache (saturating)
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_ctrl_if.master   bus,
  output logic             err,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  // TIMEOUT-1 is the largest value the timeout counter must reach.
  localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e state_q;
  state_e state_d;

  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic [TO_W-1:0]   to_cnt;

  logic in_busy;
  logic accept_ok;
  logic done_ok;
  logic fail;
  logic timeout_hit;
  logic unused_mem_stall;

  assign in_busy     = (state_q == BUSY);
  assign accept_ok   = (state_q == IDLE) && bus.req_valid && !bus.req_addr[0];
  assign timeout_hit = (to_cnt == TO_LAST);
  // mem_err outranks Done; a Done on the last allowed cycle still completes.
  assign done_ok     = in_busy && bus.mem_Done && !bus.mem_err;
  assign fail        = in_busy && (bus.mem_err || (timeout_hit && !bus.mem_Done));

  assign unused_mem_stall = bus.mem_Stall;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = bus.req_addr[0] ? ERR : BUSY;
        end
      end
      BUSY: begin
        if (fail) begin
          state_d = ERR;
        end else if (bus.mem_Done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.stall      = 1'b1;
    bus.resp_valid = 1'b0;
    err            = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = bus.req_valid;
      end
      RESP:    bus.resp_valid = 1'b1;
      ERR:     err            = 1'b1;
      default: ;
    endcase
  end

  // Request capture and memory strobes. Strobes are registered so they are
  // clean and stay put for the whole BUSY period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_ok) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wr_q    <= bus.req_wr;
        rd_q    <= !bus.req_wr;
      end
      if (done_ok) begin
        rdata_q <= wr_q ? '0 : bus.mem_DataOut;
      end
      if (in_busy && (bus.mem_Done || fail)) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
    end
  end

  assign bus.mem_Rd         = rd_q;
  assign bus.mem_Wr         = wr_q;
  assign bus.mem_Addr       = addr_q;
  assign bus.mem_DataIn     = wdata_q;
  assign bus.mem_createdump = 1'b0;
  assign bus.resp_rdata     = rdata_q;

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (done_ok),
    .clear (1'b0),
    .cnt   (access_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (done_ok && bus.mem_CacheHit),
    .clear (1'b0),
    .cnt   (hit_cnt)
  );

  // Counts cycles spent in BUSY; zero on every BUSY entry.
  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_busy),
    .clear (!in_busy),
    .cnt   (to_cnt)
  );

endmodule
